// File: rtl/aes_pkg.sv
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared AES types, S-box tables and GF(2^8) helpers for the
//           decrypt datapath.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    typedef logic [15:0][7:0] block_t;
    typedef logic [3:0][7:0]  word_t;

    // Element [0] is the leftmost byte, so the tables read like FIPS-197.
    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] c_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] a);
        return a[0] ? ({1'b0, a[7:1]} ^ 8'h8d) : {1'b0, a[7:1]};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Word byte [3] is row 0 of the column.
    function automatic word_t inv_mix_column(input word_t a);
        word_t r;
        r[3] = gmul(a[3], 8'h0e) ^ gmul(a[2], 8'h0b) ^ gmul(a[1], 8'h0d) ^ gmul(a[0], 8'h09);
        r[2] = gmul(a[3], 8'h09) ^ gmul(a[2], 8'h0e) ^ gmul(a[1], 8'h0b) ^ gmul(a[0], 8'h0d);
        r[1] = gmul(a[3], 8'h0d) ^ gmul(a[2], 8'h09) ^ gmul(a[1], 8'h0e) ^ gmul(a[0], 8'h0b);
        r[0] = gmul(a[3], 8'h0b) ^ gmul(a[2], 8'h0d) ^ gmul(a[1], 8'h09) ^ gmul(a[0], 8'h0e);
        return r;
    endfunction

    // Row r rotates right by r; byte (r,c) lives at element 15-(4r+c).
    function automatic block_t inv_shift_rows(input block_t b);
        block_t r;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[4'(15 - 4*row - col)] = b[4'(15 - 4*row - ((col - row + 4) % 4))];
            end
        end
        return r;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[2], w[1], w[0], w[3]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {c_SBOX[w[3]], c_SBOX[w[2]], c_SBOX[w[1]], c_SBOX[w[0]]};
    endfunction

    function automatic word_t get_col(input block_t b, input int c);
        return {b[4'(15 - c)], b[4'(11 - c)], b[4'(7 - c)], b[4'(3 - c)]};
    endfunction

    function automatic block_t make_block(input word_t c0, input word_t c1,
                                          input word_t c2, input word_t c3);
        return {c0[3], c1[3], c2[3], c3[3], c0[2], c1[2], c2[2], c3[2],
                c0[1], c1[1], c2[1], c3[1], c0[0], c1[0], c2[0], c3[0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_inv_round.sv
// ============================================================================
// Module  : aes_inv_round
// Brief   : Combinational AES inverse round: InvShiftRows, InvSubBytes,
//           AddRoundKey and optional InvMixColumns.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module aes_inv_round
    import aes_pkg::*;
(
    input  logic [15:0][7:0] state_i,
    input  logic [15:0][7:0] rk_i,
    input  logic             mix_en_i,
    output logic [15:0][7:0] state_o
);

    block_t w_shifted;
    block_t w_ark;
    block_t w_mixed;

    assign w_shifted = inv_shift_rows(state_i);

    for (genvar i = 0; i < 16; i++) begin : g_isb
        assign w_ark[i] = c_INV_SBOX[w_shifted[i]] ^ rk_i[i];
    end

    for (genvar c = 0; c < 4; c++) begin : g_imc
        word_t w_col;
        assign w_col         = inv_mix_column(get_col(w_ark, c));
        assign w_mixed[15-c] = w_col[3];
        assign w_mixed[11-c] = w_col[2];
        assign w_mixed[7-c]  = w_col[1];
        assign w_mixed[3-c]  = w_col[0];
    end

    assign state_o = mix_en_i ? w_mixed : w_ark;

endmodule

`default_nettype wire

// File: rtl/aes128_decrypt_core.sv
// ============================================================================
// Module  : aes128_decrypt_core
// Brief   : Iterative AES-128 decryptor, one round per clock, with on-the-fly
//           inverse key expansion from the round-10 key.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module aes128_decrypt_core
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [15:0][7:0] state_i,
    input  logic [15:0][7:0] key_i,
    output logic [15:0][7:0] out_o,
    output logic             done_o,
    output logic             busy_o
);

    block_t     state_q, state_d;
    block_t     rk_q,    rk_d;
    block_t     out_q,   out_d;
    logic [7:0] rcon_q,  rcon_d;
    logic [3:0] round_q, round_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    block_t     w_rk_prev;
    block_t     w_round_out;
    logic       w_last;

    // Undo one forward key-schedule step: recover rk[i-1] from rk[i].
    function automatic block_t inv_key_step(input block_t rk, input logic [7:0] rcon);
        word_t n0, n1, n2, n3;
        n3 = get_col(rk, 3) ^ get_col(rk, 2);
        n2 = get_col(rk, 2) ^ get_col(rk, 1);
        n1 = get_col(rk, 1) ^ get_col(rk, 0);
        n0 = get_col(rk, 0) ^ sub_word(rot_word(n3)) ^ {rcon, 24'h000000};
        return make_block(n0, n1, n2, n3);
    endfunction

    assign w_rk_prev = inv_key_step(rk_q, rcon_q);
    assign w_last    = (round_q == 4'(NR));

    aes_inv_round u_round (
        .state_i  (state_q),
        .rk_i     (w_rk_prev),
        .mix_en_i (~w_last),
        .state_o  (w_round_out)
    );

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        out_d   = out_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (!busy_q) begin
            if (start_i) begin
                state_d = state_i ^ key_i;
                rk_d    = key_i;
                rcon_d  = 8'h36;
                round_d = 4'd1;
                busy_d  = 1'b1;
            end
        end else begin
            state_d = w_round_out;
            rk_d    = w_rk_prev;
            rcon_d  = inv_xtime(rcon_q);
            if (w_last) begin
                out_d   = w_round_out;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                round_d = 4'd0;
            end else begin
                round_d = round_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            rk_q    <= '0;
            out_q   <= '0;
            rcon_q  <= 8'h00;
            round_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            out_q   <= out_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_o  = out_q;
    assign done_o = done_q;
    assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_aes128_decrypt_core.sv
// ============================================================================
// Module  : tb_aes128_decrypt_core
// Brief   : Self-checking bench for aes128_decrypt_core using FIPS-197 and
//           SP800-38A vectors with a completion scoreboard.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_aes128_decrypt_core;

    typedef struct {
        logic [127:0] ct;
        logic [127:0] rk;
        logic [127:0] pt;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [127:0] state_i;
    logic [127:0] key_i;
    logic [127:0] out_o;
    logic         done_o;
    logic         busy_o;

    int           errors     = 0;
    int           checks     = 0;
    int           done_count = 0;
    logic [127:0] exp_q[$];
    vec_t         vecs[3];

    always #5 clk = ~clk;

    aes128_decrypt_core #(.NR(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start_i),
        .state_i (state_i),
        .key_i   (key_i),
        .out_o   (out_o),
        .done_o  (done_o),
        .busy_o  (busy_o)
    );

    // FIPS byte order (byte 4c+r) to the row-major port layout.
    function automatic logic [127:0] to_blk(input logic [127:0] v);
        logic [127:0] b;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                b[127 - 8*(4*rr + cc) -: 8] = v[127 - 8*(4*cc + rr) -: 8];
        return b;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (done_o) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got out %h expected no completion", out_o);
            end else begin
                check("scoreboard_out", out_o, exp_q.pop_front());
            end
        end
    end

    task automatic launch(input logic [127:0] ct, input logic [127:0] rk, input logic [127:0] pt);
        @(negedge clk);
        start_i = 1'b1;
        state_i = ct;
        key_i   = rk;
        @(posedge clk);
        exp_q.push_back(pt);
        #1;
        check("busy_after_start", 128'(busy_o), 128'd1);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // already = edges elapsed since the start edge before this call
    task automatic wait_done(input string name, input int already);
        int cyc;
        cyc = already;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done_o && cyc < 40);
        check({name, "_latency"}, 128'(cyc), 128'd10);
        check({name, "_busy_at_done"}, 128'(busy_o), 128'd0);
    endtask

    initial begin
        int d0;
        vecs[0] = '{to_blk(128'h3925841d02dc09fbdc118597196a0b32),
                    to_blk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6),
                    to_blk(128'h3243f6a8885a308d313198a2e0370734)};
        vecs[1] = '{to_blk(128'h69c4e0d86a7b0430d8cdb78070b4c55a),
                    to_blk(128'h13111d7fe3944a17f307a78b4d2b30c5),
                    to_blk(128'h00112233445566778899aabbccddeeff)};
        vecs[2] = '{to_blk(128'h3ad77bb40d7a3660a89ecaf32466ef97),
                    to_blk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6),
                    to_blk(128'h6bc1bee22e409f96e93d7e117393172a)};

        reset   = 1'b1;
        start_i = 1'b0;
        state_i = '0;
        key_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out",  out_o, 128'd0);
        check("reset_done", 128'(done_o), 128'd0);
        check("reset_busy", 128'(busy_o), 128'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            launch(vecs[i].ct, vecs[i].rk, vecs[i].pt);
            wait_done("vector", 0);
        end

        // Back-to-back: second start on the done cycle, old result held meanwhile.
        launch(vecs[0].ct, vecs[0].rk, vecs[0].pt);
        wait_done("b2b_first", 0);
        launch(vecs[1].ct, vecs[1].rk, vecs[1].pt);
        check("b2b_out_held_at_start", out_o, vecs[0].pt);
        repeat (5) @(posedge clk);
        #1;
        check("b2b_out_held_mid", out_o, vecs[0].pt);
        wait_done("b2b_second", 5);

        // Inputs change after load must not affect the operation in flight.
        launch(vecs[1].ct, vecs[1].rk, vecs[1].pt);
        repeat (3) @(posedge clk);
        @(negedge clk);
        state_i = {$urandom, $urandom, $urandom, $urandom};
        key_i   = {$urandom, $urandom, $urandom, $urandom};
        wait_done("input_change", 3);

        // Start held high and re-pulsed while busy is ignored.
        d0 = done_count;
        launch(vecs[0].ct, vecs[0].rk, vecs[0].pt);
        start_i = 1'b1;
        state_i = vecs[1].ct;
        key_i   = vecs[1].rk;
        repeat (4) @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("busy_start_single_done", 128'(done_count - d0), 128'd1);

        // Reset during round 5 aborts with no completion.
        launch(vecs[0].ct, vecs[0].rk, vecs[0].pt);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out",  out_o, 128'd0);
        check("abort_busy", 128'(busy_o), 128'd0);
        check("abort_done", 128'(done_o), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        d0 = done_count;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_done", 128'(done_count - d0), 128'd0);
        launch(vecs[1].ct, vecs[1].rk, vecs[1].pt);
        wait_done("after_abort", 0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
